// File: rtl/pipeline_stall_sequencer.sv
// Final pipeline-register enable/flush sequencer: merges hazard-unit requests with
// instruction/data memory wait handshakes, holds flushes across a data-memory freeze.
module pipeline_stall_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hz_PC_EN_IF,
    input  logic             hz_reg_FD_EN,
    input  logic             hz_reg_FD_flush,
    input  logic             hz_reg_DE_EN,
    input  logic             hz_reg_DE_flush,
    input  logic             hz_reg_EM_EN,
    input  logic             hz_reg_EM_flush,
    input  logic             hz_reg_MW_EN,
    input  logic             imem_ready,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    output logic             PC_EN_IF,
    output logic             reg_FD_EN,
    output logic             reg_DE_EN,
    output logic             reg_EM_EN,
    output logic             reg_MW_EN,
    output logic             reg_FD_flush,
    output logic             reg_DE_flush,
    output logic             reg_EM_flush,
    output logic             reg_MW_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b01,
        ST_DWAIT = 2'b10
    } state_t;

    localparam logic [TO_W-1:0] TO_MATCH = TO_W'(TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_pend_fd;
    logic             r_pend_de;
    logic             r_pend_em;
    logic             w_pend_fd_nxt;
    logic             w_pend_de_nxt;
    logic             w_pend_em_nxt;
    logic [TO_W-1:0]  r_wd_cnt;
    logic [TO_W-1:0]  w_wd_nxt;
    logic             r_mem_timeout;
    logic             w_timeout_set;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;
    logic             w_freeze;
    logic             w_release;
    logic             w_any_flush;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [TO_W-1:0] wd_sat_inc(input logic [TO_W-1:0] v);
        return (&v) ? v : v + TO_W'(1);
    endfunction

    always_comb begin
        w_state_nxt   = r_state;
        w_pend_fd_nxt = r_pend_fd;
        w_pend_de_nxt = r_pend_de;
        w_pend_em_nxt = r_pend_em;
        w_wd_nxt      = r_wd_cnt;
        w_timeout_set = 1'b0;
        w_freeze      = 1'b0;
        w_release     = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (dmem_req_MEM && !dmem_ready) begin
                    w_freeze      = 1'b1;
                    w_pend_fd_nxt = hz_reg_FD_flush;
                    w_pend_de_nxt = hz_reg_DE_flush;
                    w_pend_em_nxt = hz_reg_EM_flush;
                    w_wd_nxt      = TO_W'(1);
                    w_state_nxt   = ST_DWAIT;
                end
            end
            ST_DWAIT: begin
                if (!dmem_ready) begin
                    w_freeze      = 1'b1;
                    w_pend_fd_nxt = r_pend_fd | hz_reg_FD_flush;
                    w_pend_de_nxt = r_pend_de | hz_reg_DE_flush;
                    w_pend_em_nxt = r_pend_em | hz_reg_EM_flush;
                    w_wd_nxt      = wd_sat_inc(r_wd_cnt);
                    w_timeout_set = (TIMEOUT != 0) && (r_wd_cnt == TO_MATCH);
                end else begin
                    // Release: the access completes; a new request this cycle is not re-checked.
                    w_release     = 1'b1;
                    w_pend_fd_nxt = 1'b0;
                    w_pend_de_nxt = 1'b0;
                    w_pend_em_nxt = 1'b0;
                    w_state_nxt   = ST_RUN;
                end
            end
            default: begin
                w_state_nxt   = ST_RUN;
                w_pend_fd_nxt = 1'b0;
                w_pend_de_nxt = 1'b0;
                w_pend_em_nxt = 1'b0;
                w_wd_nxt      = '0;
            end
        endcase
    end

    // Output merge: an imem wait bubbles ID when IF/ID would otherwise capture stale fetch data.
    always_comb begin
        PC_EN_IF     = hz_PC_EN_IF & imem_ready;
        reg_FD_flush = hz_reg_FD_flush | (w_release & r_pend_fd) | (!imem_ready & hz_reg_FD_EN);
        reg_DE_flush = hz_reg_DE_flush | (w_release & r_pend_de);
        reg_EM_flush = hz_reg_EM_flush | (w_release & r_pend_em);
        reg_MW_flush = 1'b0;
        reg_FD_EN    = hz_reg_FD_EN | reg_FD_flush;
        reg_DE_EN    = hz_reg_DE_EN | reg_DE_flush;
        reg_EM_EN    = hz_reg_EM_EN | reg_EM_flush;
        reg_MW_EN    = hz_reg_MW_EN;

        if (w_freeze) begin
            PC_EN_IF     = 1'b0;
            reg_FD_EN    = 1'b0;
            reg_DE_EN    = 1'b0;
            reg_EM_EN    = 1'b0;
            reg_MW_EN    = 1'b0;
            reg_FD_flush = 1'b0;
            reg_DE_flush = 1'b0;
            reg_EM_flush = 1'b0;
        end

        if (!rst_n) begin
            PC_EN_IF     = 1'b0;
            reg_FD_EN    = 1'b0;
            reg_DE_EN    = 1'b0;
            reg_EM_EN    = 1'b0;
            reg_MW_EN    = 1'b0;
            reg_FD_flush = 1'b1;
            reg_DE_flush = 1'b1;
            reg_EM_flush = 1'b1;
            reg_MW_flush = 1'b1;
        end
    end

    assign w_any_flush = reg_FD_flush | reg_DE_flush | reg_EM_flush | reg_MW_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_RUN;
            r_pend_fd      <= 1'b0;
            r_pend_de      <= 1'b0;
            r_pend_em      <= 1'b0;
            r_wd_cnt       <= '0;
            r_mem_timeout  <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend_fd <= w_pend_fd_nxt;
            r_pend_de <= w_pend_de_nxt;
            r_pend_em <= w_pend_em_nxt;
            r_wd_cnt  <= w_wd_nxt;
            if (w_timeout_set) begin
                r_mem_timeout <= 1'b1;
            end
            if (!PC_EN_IF) begin
                r_stall_cycles <= cnt_sat_inc(r_stall_cycles);
            end
            if (w_any_flush) begin
                r_flush_events <= cnt_sat_inc(r_flush_events);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
    assign mem_timeout  = r_mem_timeout;

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Scoreboard bench for pipeline_stall_sequencer: directed vectors push expected outputs,
// a negedge monitor pops and compares whatever the DUT presents that cycle.
module tb_pipeline_stall_sequencer;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic hz_PC_EN_IF, hz_reg_FD_EN, hz_reg_FD_flush, hz_reg_DE_EN, hz_reg_DE_flush;
    logic hz_reg_EM_EN, hz_reg_EM_flush, hz_reg_MW_EN;
    logic imem_ready, dmem_req_MEM, dmem_ready;
    logic PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN;
    logic reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush;
    logic [CNT_W-1:0] stall_cycles, flush_events;
    logic mem_timeout;

    pipeline_stall_sequencer #(.CNT_W(CNT_W), .TO_W(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .hz_PC_EN_IF(hz_PC_EN_IF), .hz_reg_FD_EN(hz_reg_FD_EN), .hz_reg_FD_flush(hz_reg_FD_flush),
        .hz_reg_DE_EN(hz_reg_DE_EN), .hz_reg_DE_flush(hz_reg_DE_flush),
        .hz_reg_EM_EN(hz_reg_EM_EN), .hz_reg_EM_flush(hz_reg_EM_flush), .hz_reg_MW_EN(hz_reg_MW_EN),
        .imem_ready(imem_ready), .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
        .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN), .reg_DE_EN(reg_DE_EN),
        .reg_EM_EN(reg_EM_EN), .reg_MW_EN(reg_MW_EN),
        .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
        .reg_EM_flush(reg_EM_flush), .reg_MW_flush(reg_MW_flush),
        .stall_cycles(stall_cycles), .flush_events(flush_events), .mem_timeout(mem_timeout)
    );

    // hz vector: {PC_EN, FD_EN, FD_flush, DE_EN, DE_flush, EM_EN, EM_flush, MW_EN}
    localparam logic [7:0] HZ_N   = 8'b1101_0101;
    localparam logic [7:0] HZ_LU  = 8'b0001_1101;
    localparam logic [7:0] HZ_FDF = 8'b1111_0101;
    localparam logic [7:0] HZ_FD0 = 8'b1001_0101;
    localparam logic [7:0] HZ_DEF = 8'b1101_1101;
    // output vector: {PC, FD_EN, DE_EN, EM_EN, MW_EN, FD_fl, DE_fl, EM_fl, MW_fl}
    localparam logic [8:0] O_PASS = 9'b11111_0000;
    localparam logic [8:0] O_RST  = 9'b00000_1111;
    localparam logic [8:0] O_FRZ  = 9'b00000_0000;

    typedef struct {
        logic [8:0]       outs;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
        logic             to;
        string            name;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;

    task automatic step(input logic rst, input logic [7:0] hz, input logic imem,
                        input logic dreq, input logic drdy, input logic [8:0] eo,
                        input logic eto, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        {hz_PC_EN_IF, hz_reg_FD_EN, hz_reg_FD_flush, hz_reg_DE_EN, hz_reg_DE_flush,
         hz_reg_EM_EN, hz_reg_EM_flush, hz_reg_MW_EN} = hz;
        imem_ready   = imem;
        dmem_req_MEM = dreq;
        dmem_ready   = drdy;
        if (!rst) begin
            m_stall = '0;
            m_flush = '0;
        end
        e.outs  = eo;
        e.stall = m_stall;
        e.flush = m_flush;
        e.to    = eto;
        e.name  = nm;
        q.push_back(e);
        if (rst) begin
            if (!eo[8]) m_stall = m_stall + 1;
            if (|eo[3:0]) m_flush = m_flush + 1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic [8:0] got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                got = {PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN,
                       reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush};
                n_tests++;
                if (got !== e.outs) begin
                    n_fail++;
                    $display("FAIL %s outs: got %b expected %b", e.name, got, e.outs);
                end
                n_tests++;
                if (stall_cycles !== e.stall || flush_events !== e.flush) begin
                    n_fail++;
                    $display("FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                             e.name, stall_cycles, flush_events, e.stall, e.flush);
                end
                n_tests++;
                if (mem_timeout !== e.to) begin
                    n_fail++;
                    $display("FAIL %s mem_timeout: got %b expected %b", e.name, mem_timeout, e.to);
                end
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0;
        {hz_PC_EN_IF, hz_reg_FD_EN, hz_reg_FD_flush, hz_reg_DE_EN, hz_reg_DE_flush,
         hz_reg_EM_EN, hz_reg_EM_flush, hz_reg_MW_EN} = HZ_N;
        imem_ready   = 1'b1;
        dmem_req_MEM = 1'b0;
        dmem_ready   = 1'b1;

        // Reset hold and release
        repeat (3) step(1'b0, HZ_N, 1'b1, 1'b0, 1'b1, O_RST, 1'b0, "reset_hold");
        step(1'b1, HZ_N, 1'b1, 1'b0, 1'b1, O_PASS, 1'b0, "reset_release");

        // Load-use pass-through
        step(1'b1, HZ_LU, 1'b1, 1'b0, 1'b1, 9'b00111_0100, 1'b0, "load_use");
        step(1'b1, HZ_N, 1'b1, 1'b0, 1'b1, O_PASS, 1'b0, "after_load_use");

        // Data-memory freeze with a flush requested mid-freeze
        step(1'b1, HZ_N, 1'b1, 1'b1, 1'b0, O_FRZ, 1'b0, "dfreeze_1");
        step(1'b1, HZ_FDF, 1'b1, 1'b1, 1'b0, O_FRZ, 1'b0, "dfreeze_2_fd_flush");
        step(1'b1, HZ_N, 1'b1, 1'b1, 1'b0, O_FRZ, 1'b0, "dfreeze_3");
        step(1'b1, HZ_N, 1'b1, 1'b1, 1'b0, O_FRZ, 1'b0, "dfreeze_4");
        step(1'b1, HZ_N, 1'b1, 1'b1, 1'b1, 9'b11111_1000, 1'b0, "drelease_pend_fd");
        step(1'b1, HZ_N, 1'b1, 1'b0, 1'b1, O_PASS, 1'b0, "after_drelease");

        // Instruction-memory wait
        step(1'b1, HZ_N, 1'b0, 1'b0, 1'b1, 9'b01111_1000, 1'b0, "imem_wait_fd_en");
        step(1'b1, HZ_FD0, 1'b0, 1'b0, 1'b1, 9'b00111_0000, 1'b0, "imem_wait_fd_hold");
        step(1'b1, HZ_N, 1'b1, 1'b0, 1'b1, O_PASS, 1'b0, "after_imem_wait");

        // Watchdog with TIMEOUT=4
        step(1'b1, HZ_N, 1'b1, 1'b1, 1'b0, O_FRZ, 1'b0, "wd_enter");
        step(1'b1, HZ_N, 1'b1, 1'b1, 1'b0, O_FRZ, 1'b0, "wd_dwait_1");
        step(1'b1, HZ_N, 1'b1, 1'b1, 1'b0, O_FRZ, 1'b0, "wd_dwait_2");
        step(1'b1, HZ_N, 1'b1, 1'b1, 1'b0, O_FRZ, 1'b0, "wd_dwait_3");
        step(1'b1, HZ_N, 1'b1, 1'b1, 1'b0, O_FRZ, 1'b0, "wd_dwait_4");
        step(1'b1, HZ_N, 1'b1, 1'b1, 1'b0, O_FRZ, 1'b1, "wd_dwait_5_timeout");
        step(1'b1, HZ_N, 1'b1, 1'b1, 1'b1, O_PASS, 1'b1, "wd_release");
        step(1'b1, HZ_N, 1'b1, 1'b0, 1'b1, O_PASS, 1'b1, "timeout_sticky");

        // Reset in the middle of DWAIT with a pending DE flush
        step(1'b1, HZ_DEF, 1'b1, 1'b1, 1'b0, O_FRZ, 1'b1, "pend_de_enter");
        step(1'b1, HZ_N, 1'b1, 1'b1, 1'b0, O_FRZ, 1'b1, "pend_de_dwait");
        step(1'b0, HZ_N, 1'b1, 1'b1, 1'b0, O_RST, 1'b0, "reset_mid_dwait");
        step(1'b1, HZ_N, 1'b1, 1'b0, 1'b1, O_PASS, 1'b0, "no_stale_de_flush");
        step(1'b1, HZ_N, 1'b1, 1'b1, 1'b1, O_PASS, 1'b0, "run_after_reset");

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left unchecked, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
